// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration, one transfer in flight,
// with an ACCESS-phase timeout that aborts a stalled slave.
module apb_master_arb #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_ack,
  output logic              req1_ack,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              tim_psel,
  output logic              tim_penable,
  output logic              tim_pwrite,
  output logic [ADDR_W-1:0] tim_paddr,
  output logic [DATA_W-1:0] tim_pwdata,
  input  logic [DATA_W-1:0] tim_prdata,
  input  logic              tim_pready,
  input  logic              tim_pslverr,
  output logic              busy
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state, state_nxt;
  logic              last_gnt;
  logic              gnt_id;
  logic [CNT_W-1:0]  cnt;
  logic              grant_c;
  logic              gnt_sel_c;
  logic              done_c;
  logic              tmo_c;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next state, arbitration and completion decode
  always_comb begin
    state_nxt = state;
    req0_ack  = 1'b0;
    req1_ack  = 1'b0;
    grant_c   = 1'b0;
    gnt_sel_c = 1'b0;
    done_c    = 1'b0;
    tmo_c     = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_c   = 1'b1;
          // On contention the requester not served last time wins
          gnt_sel_c = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
          req0_ack  = ~gnt_sel_c;
          req1_ack  = gnt_sel_c;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (tim_pready) begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          tmo_c     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, timeout counter and response registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_gnt    <= 1'b1;
      gnt_id      <= 1'b0;
      cnt         <= '0;
      tim_pwrite  <= 1'b0;
      tim_paddr   <= '0;
      tim_pwdata  <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp0_valid <= (done_c || tmo_c) && !gnt_id;
      rsp1_valid <= (done_c || tmo_c) && gnt_id;
      if (grant_c) begin
        last_gnt   <= gnt_sel_c;
        gnt_id     <= gnt_sel_c;
        cnt        <= '0;
        tim_pwrite <= gnt_sel_c ? req1_write : req0_write;
        tim_paddr  <= gnt_sel_c ? req1_addr  : req0_addr;
        tim_pwdata <= gnt_sel_c ? req1_wdata : req0_wdata;
      end
      if (state == ACCESS && !tim_pready && !tmo_c) cnt <= cnt + CNT_W'(1);
      if (done_c) begin
        rsp_rdata   <= tim_prdata;
        rsp_err     <= tim_pslverr;
        rsp_timeout <= 1'b0;
      end else if (tmo_c) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

  assign tim_psel    = (state != IDLE);
  assign tim_penable = (state == ACCESS);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: zero-wait write, round-robin, wait states
// with slave error, timeout, busy-time request drop and mid-transfer reset.
module tb_apb_master_arb;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              req0_valid, req0_write, req1_valid, req1_write;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic              req0_ack, req1_ack, rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err, rsp_timeout;
  logic              tim_psel, tim_penable, tim_pwrite;
  logic [ADDR_W-1:0] tim_paddr;
  logic [DATA_W-1:0] tim_pwdata, tim_prdata;
  logic              tim_pready, tim_pslverr, busy;

  int n_chk  = 0;
  int n_pass = 0;

  apb_master_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata),
    .req0_ack(req0_ack), .req1_ack(req1_ack),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_prdata(tim_prdata),
    .tim_pready(tim_pready), .tim_pslverr(tim_pslverr), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic psel, input logic pen);
    check({tag, ".psel"}, 64'(tim_psel), 64'(psel));
    check({tag, ".penable"}, 64'(tim_penable), 64'(pen));
  endtask

  initial begin
    sys_rst_n = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    tim_prdata = '0; tim_pready = 1'b0; tim_pslverr = 1'b0;
    #2;
    // Reset values
    check_bus("rst", 1'b0, 1'b0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.rsp0", 64'(rsp0_valid), 64'd0);
    check("rst.rsp1", 64'(rsp1_valid), 64'd0);
    check("rst.err", 64'({rsp_err, rsp_timeout, tim_pwrite}), 64'd0);
    check("rst.rdata", 64'(rsp_rdata), 64'd0);
    check("rst.paddr", 64'(tim_paddr), 64'd0);
    check("rst.pwdata", 64'(tim_pwdata), 64'd0);
    tick; tick;
    sys_rst_n = 1'b1;
    tick;

    // Zero-wait write from requester 0
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 12'h004; req0_wdata = 32'hA5A5A5A5;
    tim_pready = 1'b1;
    #1;
    check("wr.T0.ack0", 64'(req0_ack), 64'd1);
    check("wr.T0.ack1", 64'(req1_ack), 64'd0);
    check_bus("wr.T0", 1'b0, 1'b0);
    tick; req0_valid = 1'b0; #1;
    check_bus("wr.T1", 1'b1, 1'b0);
    check("wr.T1.ack0", 64'(req0_ack), 64'd0);
    check("wr.T1.busy", 64'(busy), 64'd1);
    check("wr.T1.pwrite", 64'(tim_pwrite), 64'd1);
    check("wr.T1.paddr", 64'(tim_paddr), 64'h004);
    check("wr.T1.pwdata", 64'(tim_pwdata), 64'hA5A5A5A5);
    tick;
    check_bus("wr.T2", 1'b1, 1'b1);
    check("wr.T2.rsp0", 64'(rsp0_valid), 64'd0);
    tick;
    check_bus("wr.T3", 1'b0, 1'b0);
    check("wr.T3.rsp0", 64'(rsp0_valid), 64'd1);
    check("wr.T3.rsp1", 64'(rsp1_valid), 64'd0);
    check("wr.T3.err", 64'({rsp_err, rsp_timeout}), 64'd0);
    check("wr.T3.paddr_hold", 64'(tim_paddr), 64'h004);
    tick;
    check("wr.T4.rsp0", 64'(rsp0_valid), 64'd0);

    // Round-robin from reset: both requesters hold valid for 4 transfers
    sys_rst_n = 1'b0; #1; sys_rst_n = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 12'h010; req0_wdata = 32'h11;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 12'h020;
    tim_pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d.ack0", i), 64'(req0_ack), 64'(i % 2 == 0));
      check($sformatf("rr%0d.ack1", i), 64'(req1_ack), 64'(i % 2 == 1));
      if (i > 0) begin
        check($sformatf("rr%0d.rsp0", i), 64'(rsp0_valid), 64'(i % 2 == 1));
        check($sformatf("rr%0d.rsp1", i), 64'(rsp1_valid), 64'(i % 2 == 0));
      end
      tick;
      check($sformatf("rr%0d.ackoff", i), 64'({req0_ack, req1_ack}), 64'd0);
      check($sformatf("rr%0d.paddr", i), 64'(tim_paddr), (i % 2 == 1) ? 64'h020 : 64'h010);
      tick; tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; tim_pready = 1'b0;
    #1;
    check("rr.last.rsp1", 64'(rsp1_valid), 64'd1);
    check("rr.last.ack", 64'({req0_ack, req1_ack}), 64'd0);
    tick;

    // Requester 1 read, two wait states, slave error
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 12'h0FC;
    #1;
    check("rd.T0.ack1", 64'(req1_ack), 64'd1);
    tick; req1_valid = 1'b0;
    check("rd.T1.pwrite", 64'(tim_pwrite), 64'd0);
    tick; check_bus("rd.T2", 1'b1, 1'b1);
    tick; check_bus("rd.T3", 1'b1, 1'b1);
    tick; tim_pready = 1'b1; tim_prdata = 32'h12345678; tim_pslverr = 1'b1;
    check("rd.T4.rsp1", 64'(rsp1_valid), 64'd0);
    tick; tim_pready = 1'b0; tim_pslverr = 1'b0; tim_prdata = 32'hDEADBEEF;
    check_bus("rd.T5", 1'b0, 1'b0);
    check("rd.T5.rsp1", 64'(rsp1_valid), 64'd1);
    check("rd.T5.rsp0", 64'(rsp0_valid), 64'd0);
    check("rd.T5.rdata", 64'(rsp_rdata), 64'h12345678);
    check("rd.T5.err", 64'(rsp_err), 64'd1);
    check("rd.T5.tmo", 64'(rsp_timeout), 64'd0);
    tick;

    // Timeout: slave never ready, TIMEOUT_CYC = 4
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 12'h100;
    #1; check("to.T0.ack0", 64'(req0_ack), 64'd1);
    tick; req0_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      check_bus($sformatf("to.acc%0d", c), 1'b1, 1'b1);
    end
    tick;
    check_bus("to.end", 1'b0, 1'b0);
    check("to.rsp0", 64'(rsp0_valid), 64'd1);
    check("to.err", 64'({rsp_err, rsp_timeout}), 64'h3);
    check("to.rdata", 64'(rsp_rdata), 64'd0);
    tick;

    // Requester 0 pulses valid while busy with requester 1
    req1_valid = 1'b1; req1_addr = 12'h200;
    #1; check("drop.T0.ack1", 64'(req1_ack), 64'd1);
    tick; req1_valid = 1'b0; req0_valid = 1'b1; #1;
    check("drop.T1.ack0", 64'(req0_ack), 64'd0);
    tick; req0_valid = 1'b0;
    tick; tick; tick;
    tick;
    check("drop.T6.rsp1", 64'(rsp1_valid), 64'd1);
    check("drop.T6.rsp0", 64'(rsp0_valid), 64'd0);
    check("drop.T6.ack0", 64'(req0_ack), 64'd0);
    tick;
    check("drop.T7.busy", 64'(busy), 64'd0);
    check_bus("drop.T7", 1'b0, 1'b0);

    // Reset asserted in ACCESS abandons the transfer
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 12'h300; req0_wdata = 32'h5;
    tick; req0_valid = 1'b0;
    tick; check_bus("rst.acc", 1'b1, 1'b1);
    req0_valid = 1'b1; req0_addr = 12'h304;
    sys_rst_n = 1'b0; #1;
    check_bus("rst.mid", 1'b0, 1'b0);
    check("rst.mid.busy", 64'(busy), 64'd0);
    check("rst.mid.rsp0", 64'(rsp0_valid), 64'd0);
    sys_rst_n = 1'b1;
    tick;
    check_bus("rst.regrant", 1'b1, 1'b0);
    check("rst.regrant.paddr", 64'(tim_paddr), 64'h304);
    check("rst.regrant.rsp0", 64'(rsp0_valid), 64'd0);
    req0_valid = 1'b0; tim_pready = 1'b1;
    tick; tick;
    check("rst.done.rsp0", 64'(rsp0_valid), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
